// File: rtl/cache_arbiter_pkg.sv
// lc3b_types: shared types for the L1/L2 cache arbiter.
//   lc3b_word   - 16-bit machine word / line address
//   cache_line  - 128-bit cache line
//   arb_state_t - arbiter FSM state encoding
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] cache_line;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2
  } arb_state_t;

  // A client is requesting when either its read or its write strobe is high.
  function automatic logic req_active(input logic rd, input logic wr);
    return rd | wr;
  endfunction

endpackage

// File: rtl/cache_arbiter_if.sv
// cache_arbiter_if: bundles the I-cache, D-cache and downstream (L2) memory
// ports around the arbiter.
//   slave  modport - seen by the arbiter (client requests and l2 response in,
//                    client responses and l2 request out)
//   master modport - seen by the surrounding clients/memory model
interface cache_arbiter_if;
  import lc3b_types::*;

  logic      i_pmem_read;
  logic      i_pmem_write;
  lc3b_word  i_pmem_address;
  cache_line i_pmem_wdata;
  logic      i_pmem_resp;
  cache_line i_pmem_rdata;

  logic      d_pmem_read;
  logic      d_pmem_write;
  lc3b_word  d_pmem_address;
  cache_line d_pmem_wdata;
  logic      d_pmem_resp;
  cache_line d_pmem_rdata;

  logic      l2_read;
  logic      l2_write;
  lc3b_word  l2_address;
  cache_line l2_wdata;
  logic      l2_resp;
  cache_line l2_rdata;

  logic      arb_busy;

  modport slave (
    input  i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
    input  d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    input  l2_resp, l2_rdata,
    output i_pmem_resp, i_pmem_rdata, d_pmem_resp, d_pmem_rdata,
    output l2_read, l2_write, l2_address, l2_wdata, arb_busy
  );

  modport master (
    output i_pmem_read, i_pmem_write, i_pmem_address, i_pmem_wdata,
    output d_pmem_read, d_pmem_write, d_pmem_address, d_pmem_wdata,
    output l2_resp, l2_rdata,
    input  i_pmem_resp, i_pmem_rdata, d_pmem_resp, d_pmem_rdata,
    input  l2_read, l2_write, l2_address, l2_wdata, arb_busy
  );

endinterface

// File: rtl/cache_arbiter_req_reg.sv
// arb_req_reg: latch for the granted request (address, wdata, read, write).
//   load  - capture in_* (read wins if read and write are both high)
//   clear - drop read/write at the end of a transaction
//   outputs drive the downstream port directly, so they are registered.
module arb_req_reg
  import lc3b_types::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      load,
  input  logic      clear,
  input  lc3b_word  in_address,
  input  cache_line in_wdata,
  input  logic      in_read,
  input  logic      in_write,
  output lc3b_word  address,
  output cache_line wdata,
  output logic      read,
  output logic      write
);

  // Request latch; clear and load are never asserted together by the FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      address <= 16'h0000;
      wdata   <= 128'h0;
      read    <= 1'b0;
      write   <= 1'b0;
    end else if (clear) begin
      read    <= 1'b0;
      write   <= 1'b0;
    end else if (load) begin
      address <= in_address;
      wdata   <= in_wdata;
      read    <= in_read;
      // Read+write together is illegal; keep the read, drop the write.
      write   <= in_write & ~in_read;
    end
  end

endmodule

// File: rtl/cache_arbiter.sv
// cache_arbiter: round-robin arbiter between the L1 I-cache and D-cache for
// one shared downstream memory port.
//   clk   - rising-edge clock
//   rst_n - asynchronous active-low reset
//   bus   - slave side of cache_arbiter_if (client requests/responses,
//           downstream request/response, arb_busy)
// One request is granted at a time and held from the latch until l2_resp;
// the response is steered combinationally to the granted client.
module cache_arbiter (
  input  logic            clk,
  input  logic            rst_n,
  cache_arbiter_if.slave  bus
);
  import lc3b_types::*;

  localparam logic [1:0] S_IDLE    = 2'(IDLE);
  localparam logic [1:0] S_GRANT_I = 2'(GRANT_I);
  localparam logic [1:0] S_GRANT_D = 2'(GRANT_D);

  logic [1:0] state;
  logic [1:0] state_next;
  logic       last_grant;      // 0 = I granted last, 1 = D granted last
  logic       last_grant_next;
  logic       load;
  logic       clear;
  logic       sel_d;
  logic       i_req;
  logic       d_req;

  logic      req_read;
  logic      req_write;
  lc3b_word  req_address;
  cache_line req_wdata;

  assign i_req = req_active(bus.i_pmem_read, bus.d_pmem_read & 1'b0 | bus.i_pmem_write);
  assign d_req = req_active(bus.d_pmem_read, bus.d_pmem_write);

  // Arbitration and transaction sequencing.
  always_comb begin
    state_next      = state;
    last_grant_next = last_grant;
    load            = 1'b0;
    clear           = 1'b0;
    sel_d           = 1'b0;
    case (state)
      S_IDLE: begin
        // On a tie the client not granted last time wins.
        if (i_req && (!d_req || last_grant)) begin
          state_next      = S_GRANT_I;
          last_grant_next = 1'b0;
          load            = 1'b1;
        end else if (d_req) begin
          state_next      = S_GRANT_D;
          last_grant_next = 1'b1;
          load            = 1'b1;
          sel_d           = 1'b1;
        end else begin
          state_next      = S_IDLE;
        end
      end
      S_GRANT_I, S_GRANT_D: begin
        // Always pass through IDLE after a response so the client's
        // still-held request is not granted a second time.
        if (bus.l2_resp) begin
          state_next = S_IDLE;
          clear      = 1'b1;
        end else begin
          state_next = state;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // FSM state and round-robin pointer; I wins the first tie after reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      last_grant <= 1'b1;
    end else begin
      state      <= state_next;
      last_grant <= last_grant_next;
    end
  end

  arb_req_reg u_req_reg (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .clear      (clear),
    .in_address (sel_d ? bus.d_pmem_address : bus.i_pmem_address),
    .in_wdata   (sel_d ? bus.d_pmem_wdata   : bus.i_pmem_wdata),
    .in_read    (sel_d ? bus.d_pmem_read    : bus.i_pmem_read),
    .in_write   (sel_d ? bus.d_pmem_write   : bus.i_pmem_write),
    .address    (req_address),
    .wdata      (req_wdata),
    .read       (req_read),
    .write      (req_write)
  );

  assign bus.l2_read    = req_read;
  assign bus.l2_write   = req_write;
  assign bus.l2_address = req_address;
  assign bus.l2_wdata   = req_wdata;

  // Zero-latency response steering; a response in IDLE reaches no client.
  assign bus.i_pmem_resp  = bus.l2_resp & (state == S_GRANT_I);
  assign bus.d_pmem_resp  = bus.l2_resp & (state == S_GRANT_D);
  assign bus.i_pmem_rdata = bus.l2_rdata;
  assign bus.d_pmem_rdata = bus.l2_rdata;

  assign bus.arb_busy = (state != S_IDLE);

endmodule

// File: tb/tb_cache_arbiter.sv
// Self-checking bench for cache_arbiter: randomized client traffic, a
// transaction-level arbitration model feeding expectation queues, and an
// independent monitor that compares whenever the DUT presents a request or
// a response is delivered.
module tb_cache_arbiter;
  import lc3b_types::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cache_arbiter_if bus ();

  cache_arbiter dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    int           client;
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] wdata;
  } req_t;

  typedef struct {
    int           client;   // 0 = I, 1 = D, 2 = nobody
    logic [127:0] rdata;
  } rsp_t;

  req_t exp_req[$];
  rsp_t exp_rsp[$];

  // Client-side model: the request each client is holding.
  logic         pend[2];
  logic         p_rd[2];
  logic         p_wr[2];
  logic [15:0]  p_addr[2];
  logic [127:0] p_wdata[2];
  logic [15:0]  drv_addr[2];
  logic [127:0] drv_wdata[2];
  int           last_granted = 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive();
    bus.i_pmem_read    = pend[0] & p_rd[0];
    bus.i_pmem_write   = pend[0] & p_wr[0];
    bus.i_pmem_address = drv_addr[0];
    bus.i_pmem_wdata   = drv_wdata[0];
    bus.d_pmem_read    = pend[1] & p_rd[1];
    bus.d_pmem_write   = pend[1] & p_wr[1];
    bus.d_pmem_address = drv_addr[1];
    bus.d_pmem_wdata   = drv_wdata[1];
  endtask

  task automatic set_req(input int c, input logic rd, input logic wr,
                         input logic [15:0] a, input logic [127:0] d);
    pend[c]      = 1'b1;
    p_rd[c]      = rd;
    p_wr[c]      = wr;
    p_addr[c]    = a;
    p_wdata[c]   = d;
    drv_addr[c]  = a;
    drv_wdata[c] = d;
  endtask

  // kind 0/2 read, 1 write, 3 illegal read+write
  task automatic new_req(input int c);
    int k;
    k = $urandom_range(0, 3);
    set_req(c, (k != 1), (k == 1 || k == 3), 16'($urandom), rand_line());
  endtask

  // One arbitration round: decide the winner from the rules, expect its
  // request downstream one cycle later, answer after a random delay.
  task automatic round(input int rereq_pct, input int delay);
    int w;
    int n;
    int cycles;
    logic [127:0] rd;
    if (!pend[0] && !pend[1]) begin
      if ($urandom_range(0, 99) < 60) new_req(0);
      if ($urandom_range(0, 99) < 60) new_req(1);
      drive();
      if (!pend[0] && !pend[1]) step();
      return;
    end
    if (pend[0] && pend[1]) w = 1 - last_granted;
    else w = pend[0] ? 0 : 1;
    last_granted = w;
    exp_req.push_back('{w, p_rd[w], p_wr[w] & ~p_rd[w], p_addr[w], p_wdata[w]});
    cycles = 0;
    for (int i = 0; i < 8; i++) begin
      step();
      cycles++;
      if (bus.l2_read || bus.l2_write) break;
    end
    check("req_latency", 128'(cycles), 128'd1);
    check("busy_in_grant", bus.arb_busy, 1'b1);
    n = (delay < 0) ? $urandom_range(0, 3) : delay;
    for (int i = 0; i < n; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        drv_addr[w]  = 16'($urandom);
        drv_wdata[w] = rand_line();
        drive();
      end
      step();
    end
    rd = rand_line();
    bus.l2_rdata = rd;
    bus.l2_resp  = 1'b1;
    exp_rsp.push_back('{w, rd});
    step();
    bus.l2_resp  = 1'b0;
    bus.l2_rdata = rand_line();
    pend[w] = 1'b0;
    if ($urandom_range(0, 99) < rereq_pct) new_req(w);
    if (!pend[1 - w] && $urandom_range(0, 99) < rereq_pct) new_req(1 - w);
    drive();
  endtask

  // Monitor: pops expectations when a request appears or a response is seen.
  initial begin
    logic prev_active;
    logic active;
    logic cur_valid;
    req_t cur;
    rsp_t e;
    prev_active = 1'b0;
    cur_valid = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_active = 1'b0;
        cur_valid = 1'b0;
      end else begin
        active = bus.l2_read | bus.l2_write;
        if (active && !prev_active) begin
          check("req_expected", 128'(exp_req.size() != 0), 128'd1);
          if (exp_req.size() != 0) begin
            cur = exp_req.pop_front();
            cur_valid = 1'b1;
          end else begin
            cur_valid = 1'b0;
          end
        end
        if (active && cur_valid) begin
          check("l2_read", bus.l2_read, cur.rd);
          check("l2_write", bus.l2_write, cur.wr);
          check("l2_address", bus.l2_address, cur.addr);
          check("l2_wdata", bus.l2_wdata, cur.wdata);
        end
        if (bus.l2_resp) begin
          check("rsp_expected", 128'(exp_rsp.size() != 0), 128'd1);
          if (exp_rsp.size() != 0) begin
            e = exp_rsp.pop_front();
            check("i_pmem_resp", bus.i_pmem_resp, (e.client == 0));
            check("d_pmem_resp", bus.d_pmem_resp, (e.client == 1));
            check("i_pmem_rdata", bus.i_pmem_rdata, e.rdata);
            check("d_pmem_rdata", bus.d_pmem_rdata, e.rdata);
          end
        end else begin
          check("no_resp_i", bus.i_pmem_resp, 1'b0);
          check("no_resp_d", bus.d_pmem_resp, 1'b0);
        end
        prev_active = active;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [127:0] rd;
    for (int c = 0; c < 2; c++) begin
      pend[c] = 1'b0; p_rd[c] = 1'b0; p_wr[c] = 1'b0;
      p_addr[c] = 16'h0000; p_wdata[c] = 128'h0;
      drv_addr[c] = 16'h0000; drv_wdata[c] = 128'h0;
    end
    drive();
    bus.l2_resp = 1'b0;
    rd = rand_line();
    bus.l2_rdata = rd;
    #2;
    check("rst_l2_read", bus.l2_read, 1'b0);
    check("rst_l2_write", bus.l2_write, 1'b0);
    check("rst_l2_address", bus.l2_address, 16'h0000);
    check("rst_l2_wdata", bus.l2_wdata, 128'h0);
    check("rst_i_resp", bus.i_pmem_resp, 1'b0);
    check("rst_d_resp", bus.d_pmem_resp, 1'b0);
    check("rst_busy", bus.arb_busy, 1'b0);
    check("rst_i_rdata", bus.i_pmem_rdata, rd);
    check("rst_d_rdata", bus.d_pmem_rdata, rd);
    step();
    step();
    rst_n = 1'b1;
    step();

    // First tie after reset: I read wins, D write follows.
    set_req(0, 1'b1, 1'b0, 16'h0040, rand_line());
    set_req(1, 1'b0, 1'b1, 16'h0080, {8{16'h1111}});
    drive();
    round(0, 4);
    round(0, -1);

    // Randomized traffic.
    for (int i = 0; i < 150; i++) round(70, -1);

    // Continuous contention: strict alternation.
    for (int i = 0; i < 12; i++) round(100, -1);

    // Drain outstanding requests.
    for (int i = 0; i < 4; i++) begin
      if (pend[0] || pend[1]) round(0, -1);
    end

    // Async reset in the middle of an I read.
    step();
    set_req(0, 1'b1, 1'b0, 16'h1230, rand_line());
    drive();
    exp_req.push_back('{0, 1'b1, 1'b0, 16'h1230, p_wdata[0]});
    step();
    step();
    #1;
    rst_n = 1'b0;
    #1;
    check("arst_l2_read", bus.l2_read, 1'b0);
    check("arst_l2_write", bus.l2_write, 1'b0);
    check("arst_busy", bus.arb_busy, 1'b0);
    step();
    pend[0] = 1'b0;
    drive();
    rst_n = 1'b1;
    last_granted = 1;
    step();

    // Late/stray l2_resp while idle reaches nobody.
    rd = rand_line();
    bus.l2_rdata = rd;
    bus.l2_resp = 1'b1;
    exp_rsp.push_back('{2, rd});
    step();
    bus.l2_resp = 1'b0;
    check("stray_busy", bus.arb_busy, 1'b0);
    check("stray_l2_read", bus.l2_read, 1'b0);

    // Next tie after reset goes to I again.
    new_req(0);
    new_req(1);
    drive();
    round(0, -1);
    round(0, -1);

    repeat (4) step();
    check("req_queue_empty", 128'(exp_req.size()), 128'd0);
    check("rsp_queue_empty", 128'(exp_rsp.size()), 128'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
